// File: rtl/turn_timer_pkg.sv
// game_pkg: state codes shared with the game state machine and the turn timer control states.
package game_pkg;
  typedef enum logic [3:0] {
    S0 = 4'h0,
    S1 = 4'h1,
    S2 = 4'h2,
    S5 = 4'h5,
    S6 = 4'h6,
    S7 = 4'h7
  } state_t;

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} ctrl_t;

  function automatic logic is_timed(input logic [3:0] s);
    return s == S1 || s == S6 || s == S7;
  endfunction
endpackage

// File: rtl/turn_timer_tick_gen.sv
// tick_gen: one-second prescaler, pulses tick for one cycle at its terminal count.
module tick_gen #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int W = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [W-1:0] TC = W'(CLK_HZ - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == TC;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/turn_timer.sv
// turn_timer: restarts a per-turn countdown on entry to a timed game state and pulses finished on expiry.
module turn_timer
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TURN_SECONDS = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] estado,
  input  logic       pause,
  output logic       finished,
  output logic       running,
  output logic [6:0] secs_left,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units
);
  if (TURN_SECONDS < 1 || TURN_SECONDS > 99) begin : g_bad_turn
    $error("TURN_SECONDS must be in 1..99");
  end
  localparam logic [6:0] T = 7'(TURN_SECONDS);
  logic [3:0] estado_q;
  ctrl_t      ctrl, ctrl_d;
  logic [6:0] secs_d, rem;
  logic       fin_d, chg, tick;
  assign chg     = estado != estado_q;
  assign running = ctrl == RUN;
  tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (chg || ctrl != RUN),
    .en   (running && !pause),
    .tick (tick)
  );
  // A state change always takes priority over an expiry landing on the same cycle.
  always_comb begin
    ctrl_d = ctrl;
    secs_d = secs_left;
    fin_d  = 1'b0;
    if (chg) begin
      ctrl_d = is_timed(estado) ? RUN : IDLE;
      secs_d = T;
    end else if (running && tick) begin
      secs_d = secs_left - 7'd1;
      fin_d  = secs_left == 7'd1;
      ctrl_d = fin_d ? EXPIRED : RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ctrl      <= IDLE;
      estado_q  <= 4'h0;
      secs_left <= T;
      finished  <= 1'b0;
    end else begin
      ctrl      <= ctrl_d;
      estado_q  <= estado;
      secs_left <= secs_d;
      finished  <= fin_d;
    end
  always_comb begin
    rem      = secs_left;
    bcd_tens = 4'd0;
    for (int i = 0; i < 9; i++)
      if (rem >= 7'd10) begin
        rem      = rem - 7'd10;
        bcd_tens = bcd_tens + 4'd1;
      end
    bcd_units = rem[3:0];
  end
endmodule

// File: tb/tb_turn_timer.sv
// tb_turn_timer: directed and random stimulus against an elapsed-time reference model.
module tb_turn_timer;
  localparam int HZ = 10;
  localparam int T  = 3;
  logic       clk = 1'b0, rst_n = 1'b0, pause = 1'b0, pause99 = 1'b0;
  logic [3:0] estado = 4'h0, estado99 = 4'h0;
  logic       finished, running, finished99, running99;
  logic [6:0] secs_left, secs99;
  logic [3:0] bcd_tens, bcd_units, tens99, units99;
  int         compared = 0, mismatched = 0;
  int         m_mode, m_active, m_prev;
  logic       m_fin;
  logic [3:0] codes [6] = '{4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7};

  turn_timer #(.CLK_HZ(HZ), .TURN_SECONDS(T)) dut (
    .clk(clk), .rst_n(rst_n), .estado(estado), .pause(pause), .finished(finished),
    .running(running), .secs_left(secs_left), .bcd_tens(bcd_tens), .bcd_units(bcd_units)
  );
  turn_timer #(.CLK_HZ(HZ), .TURN_SECONDS(99)) dut99 (
    .clk(clk), .rst_n(rst_n), .estado(estado99), .pause(pause99), .finished(finished99),
    .running(running99), .secs_left(secs99), .bcd_tens(tens99), .bcd_units(units99)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_active = 0; m_prev = 0; m_fin = 1'b0;
  endtask

  // mode: 0 idle, 1 counting, 2 expired; seconds left derive from active (unpaused) cycles since load
  task automatic model_edge(input int e, input logic p);
    if (e != m_prev) begin
      m_mode   = (e == 1 || e == 6 || e == 7) ? 1 : 0;
      m_active = 0;
      m_fin    = 1'b0;
    end else if (m_mode == 1 && !p) begin
      m_active++;
      m_fin = m_active == T * HZ;
      if (m_fin) m_mode = 2;
    end else m_fin = 1'b0;
    m_prev = e;
  endtask

  task automatic check_all(input string tag);
    int s;
    s = m_mode == 0 ? T : m_mode == 1 ? T - m_active / HZ : 0;
    chk({tag, ".finished"}, 32'(finished), 32'(m_fin));
    chk({tag, ".running"}, 32'(running), 32'(m_mode == 1));
    chk({tag, ".secs_left"}, 32'(secs_left), 32'(s));
    chk({tag, ".bcd_tens"}, 32'(bcd_tens), 32'(s / 10));
    chk({tag, ".bcd_units"}, 32'(bcd_units), 32'(s % 10));
  endtask

  task automatic step(input string tag, input logic [3:0] e, input logic p);
    estado = e;
    pause  = p;
    @(posedge clk);
    model_edge(int'(e), p);
    #1;
    check_all(tag);
  endtask

  initial begin
    int s;
    logic [3:0] e;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk) rst_n = 1'b1;
    // basic expiry
    step("t1_load", 4'h1, 1'b0);
    repeat (30) step("t1_run", 4'h1, 1'b0);
    chk("t1_fin_at_30", 32'(finished), 32'd1);
    chk("t1_expired", 32'(running), 32'd0);
    // no re-fire, then untimed code
    repeat (100) step("t2_hold", 4'h1, 1'b0);
    chk("t2_secs_zero", 32'(secs_left), 32'd0);
    step("t2_idle", 4'h2, 1'b0);
    chk("t2_idle_secs", 32'(secs_left), 32'd3);
    // timed->timed reload
    step("t3_load", 4'h6, 1'b0);
    repeat (14) step("t3_run", 4'h6, 1'b0);
    step("t3_reload", 4'h7, 1'b0);
    chk("t3_reload_secs", 32'(secs_left), 32'd3);
    repeat (30) step("t3_run2", 4'h7, 1'b0);
    chk("t3_fin_at_45", 32'(finished), 32'd1);
    // pause for cycles 5..24
    step("t4_load", 4'h1, 1'b0);
    repeat (4) step("t4_run", 4'h1, 1'b0);
    repeat (20) step("t4_pause", 4'h1, 1'b1);
    repeat (26) step("t4_run2", 4'h1, 1'b0);
    chk("t4_fin_at_50", 32'(finished), 32'd1);
    // collision: change lands on the expiry cycle
    step("t5_idle", 4'h2, 1'b0);
    step("t5_load", 4'h1, 1'b0);
    repeat (29) step("t5_run", 4'h1, 1'b0);
    step("t5_collide", 4'h6, 1'b0);
    chk("t5_no_fin", 32'(finished), 32'd0);
    chk("t5_reload", 32'(secs_left), 32'd3);
    // asynchronous reset mid-count, then restart with estado already timed
    repeat (11) step("t5_run2", 4'h6, 1'b0);
    #3 rst_n = 1'b0;
    #1 model_reset();
    check_all("t5_async_rst");
    @(negedge clk) rst_n = 1'b1;
    step("t5_restart", 4'h6, 1'b0);
    chk("t5_restart_run", 32'(running), 32'd1);
    repeat (30) step("t5_run3", 4'h6, 1'b0);
    chk("t5_restart_fin", 32'(finished), 32'd1);
    // random walk over state codes and pause
    repeat (600) begin
      e = ($urandom_range(0, 39) == 0) ? codes[$urandom_range(0, 5)] : estado;
      step("rand", e, $urandom_range(0, 5) == 0);
    end
    // BCD split on a 99-second turn
    estado99 = 4'h1;
    @(posedge clk);
    #1;
    chk("bcd99_tens_load", 32'(tens99), 32'd9);
    chk("bcd99_units_load", 32'(units99), 32'd9);
    for (int k = 1; k <= 995; k++) begin
      @(posedge clk);
      #1;
      s = k >= 990 ? 0 : 99 - k / 10;
      chk("bcd99_secs", 32'(secs99), 32'(s));
      chk("bcd99_tens", 32'(tens99), 32'(s / 10));
      chk("bcd99_units", 32'(units99), 32'(s % 10));
      chk("bcd99_fin", 32'(finished99), 32'(k == 990));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
